// File: rtl/aes_dec_pkg.sv
// Shared constants (round counts, InvMixColumns coefficients) and the FSM state type
// for the AES decryption core.
package aes_const;
  localparam logic [3:0] NR128 = 4'd10;
  localparam logic [3:0] NR192 = 4'd12;
  localparam logic [3:0] NR256 = 4'd14;

  // First row of the InvMixColumns matrix; later rows are right-rotations of it.
  localparam logic [7:0] INV_MIX_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      2'd1:    return NR192;
      2'd2:    return NR256;
      default: return NR128;
    endcase
  endfunction
endpackage

package aes_wire;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } dec_state_e;
endpackage

// File: rtl/aes_inv_mixcol.sv
// One-column InvMixColumns; GF(2^8) products via log/antilog lookup tables.
module aes_inv_mixcol
  import aes_const::*;
(
  input  logic [31:0] col_i,
  input  logic [7:0]  EXP3 [0:255],
  input  logic [7:0]  LN3  [0:255],
  output logic [31:0] col_o
);
  logic [7:0] a    [4];
  logic [7:0] la   [4];
  logic [7:0] lc   [4];
  logic [7:0] term [4][4];

  for (genvar j = 0; j < 4; j++) begin : g_in
    assign a[j]  = col_i[31-8*j -: 8];
    assign la[j] = LN3[a[j]];
    assign lc[j] = LN3[INV_MIX_COEF[j]];
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_term
      logic [8:0] s;
      logic [7:0] s_mod;
      assign s     = {1'b0, la[j]} + {1'b0, lc[(j-r+4)%4]};
      assign s_mod = (s >= 9'd255) ? 8'(s - 9'd255) : s[7:0];
      // log(0) is undefined, so a zero operand forces a zero product
      assign term[r][j] = (a[j] == 8'h00) ? 8'h00 : EXP3[s_mod];
    end
    assign col_o[31-8*r -: 8] = term[r][0] ^ term[r][1] ^ term[r][2] ^ term[r][3];
  end
endmodule

// File: rtl/aes_dec.sv
// Iterative AES block decryptor, one round per clock. Define AES_DEC_LONGKEY_EN to
// honour key_len (192/256-bit keys); otherwise Nr is fixed at 10.
module aes_dec
  import aes_const::*;
  import aes_wire::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [1:0]   key_len,
  input  logic [31:0]  KExp [0:119],
  input  logic [7:0]   IBox [0:255],
  input  logic [7:0]   EXP3 [0:255],
  input  logic [7:0]   LN3  [0:255],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  logic [3:0] nr_sel;

`ifdef AES_DEC_LONGKEY_EN
  localparam int unsigned KW_LAST = 59;
  assign nr_sel = nr_of(key_len);
`else
  localparam int unsigned KW_LAST = 43;
  logic [1:0] unused_key_len;
  assign nr_sel         = NR128;
  assign unused_key_len = key_len;
`endif

  // Key words beyond the last round key are never consumed.
  logic [31:0] unused_kfold [KW_LAST+1:120];
  assign unused_kfold[120] = '0;
  for (genvar i = KW_LAST + 1; i < 120; i++) begin : g_kfold
    assign unused_kfold[i] = unused_kfold[i+1] ^ KExp[i];
  end

  dec_state_e   st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   round_q, round_d;
  logic         ovalid_q, ovalid_d;

  logic [7:0]   sb [16];
  logic [127:0] rk_cur, rk_acc, ark, mix;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [6:0] idx_cur, idx_acc;
    assign idx_cur = {1'b0, round_q, 2'b00} + 7'(c);
    assign idx_acc = {1'b0, nr_sel, 2'b00} + 7'(c);
    assign rk_cur[127-32*c -: 32] = (idx_cur <= 7'(KW_LAST)) ? KExp[idx_cur] : '0;
    assign rk_acc[127-32*c -: 32] = (idx_acc <= 7'(KW_LAST)) ? KExp[idx_acc] : '0;

    // InvShiftRows folded into the S-box read: row r of column c comes from column c-r
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[4*c+r] = IBox[state_q[127-8*(4*((c-r+4)%4)+r) -: 8]];
    end

    assign ark[127-32*c -: 32] = {sb[4*c], sb[4*c+1], sb[4*c+2], sb[4*c+3]}
                                 ^ rk_cur[127-32*c -: 32];

    aes_inv_mixcol u_imc (
      .col_i (ark[127-32*c -: 32]),
      .EXP3  (EXP3),
      .LN3   (LN3),
      .col_o (mix[127-32*c -: 32])
    );
  end

  always_comb begin
    st_d     = st_q;
    state_d  = state_q;
    round_d  = round_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = data_in ^ rk_acc;
          round_d = nr_sel - 4'd1;
          st_d    = (nr_sel == 4'd1) ? FINAL : ROUND;
        end
      end
      ROUND: begin
        state_d = mix;
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) st_d = FINAL;
      end
      FINAL: begin
        state_d  = ark;
        dout_d   = ark;
        ovalid_d = 1'b1;
        st_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          st_d     = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      state_q  <= '0;
      dout_q   <= '0;
      round_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      state_q  <= state_d;
      dout_q   <= dout_d;
      round_q  <= round_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign in_ready  = (st_q == IDLE) && !rst;
  assign busy      = (st_q != IDLE);
  assign out_valid = ovalid_q;
  assign data_out  = dout_q;
endmodule

// File: tb/tb_aes_dec.sv
// Bench for aes_dec: builds the S-box/log tables and key schedule itself and checks
// the core against a byte-level reference decryptor.
module tb_aes_dec;
  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid, busy;
  logic [127:0] data_in, data_out;
  logic [1:0]   key_len;
  logic [31:0]  KExp [0:119];
  logic [7:0]   IBox [0:255];
  logic [7:0]   EXP3 [0:255];
  logic [7:0]   LN3  [0:255];
  logic [7:0]   sbox [0:255];
  logic [31:0]  w    [0:59];
  int           checks = 0;
  int           failures = 0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

  aes_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_len   (key_len),
    .KExp      (KExp),
    .IBox      (IBox),
    .EXP3      (EXP3),
    .LN3       (LN3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  task automatic build_tables();
    logic [7:0] v, inv, s;
    v = 8'h01;
    for (int i = 0; i < 256; i++) begin
      EXP3[i] = v;
      v = v ^ xt(v);
    end
    LN3[0] = 8'h00;
    for (int i = 0; i < 255; i++) LN3[EXP3[i]] = 8'(i);
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : EXP3[8'((255 - int'(LN3[x])) % 255)];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      IBox[s] = 8'(x);
    end
  endtask

  // key is left-aligned: first key byte in [255:248]
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = 32'(key >> (32 * (7 - i)));
    for (int i = nk; i < 60; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 120; i++) KExp[i] = (i < 4 * (nk + 7)) ? w[i] : $urandom;
  endtask

  function automatic logic [7:0] kb(input int r, input int i);
    return 8'(w[4*r + i/4] >> (8 * (3 - i % 4)));
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = 8'(ct >> (8 * (15 - i))) ^ kb(nr, i);
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*((c+rr)%4)+rr] = IBox[s[4*c+rr]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ kb(r, i);
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [127:0] ct, input logic [1:0] kl,
                        input int nr, input logic [127:0] pt, input int hold);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    chk({tag, "/in_ready"}, 128'(in_ready), 128'(1));
    data_in  = ct;
    key_len  = kl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    key_len  = 2'($urandom);
    chk({tag, "/accepted"}, {125'd0, busy, in_ready, out_valid}, {125'd0, 3'b100});
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, "/latency"}, 128'(cnt), 128'(nr));
    chk({tag, "/data"}, data_out, pt);
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == 1);
      data_in  = ~ct;
      tick();
      chk({tag, "/hold_data"}, data_out, pt);
      chk({tag, "/hold_flags"}, {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b101});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/release"}, {125'd0, out_valid, busy, in_ready}, {125'd0, 3'b001});
    if (hold > 0) begin
      repeat (3) tick();
      chk({tag, "/no_queue"}, {126'd0, busy, out_valid}, 128'd0);
    end
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] ct;
    logic [1:0]   kl;
    int           nk;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_len = 2'd0;
    build_tables();
    expand({KEY1, 128'h0}, 4);
    tick();
    tick();
    chk("reset_flags", {125'd0, out_valid, busy, in_ready}, 128'd0);
    chk("reset_data", data_out, 128'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 128'(in_ready), 128'(1));

    run_op("kat128_a", CT1, 2'd0, 10, PT1, 0);
    expand({KEY2, 128'h0}, 4);
    run_op("kat128_b", CT2, 2'd0, 10, PT2, 0);
`ifdef AES_DEC_LONGKEY_EN
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    run_op("kat256", 128'h8ea2b7ca516745bfeafc49904b496089, 2'd2, 14, PT2, 0);
    expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    run_op("kat192", 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 2'd1, 12, PT2, 0);
    expand({KEY2, 128'h0}, 4);
    run_op("kl3_as_128", CT2, 2'd3, 10, PT2, 0);
`else
    run_op("kl_ignored", CT2, 2'd2, 10, PT2, 0);
`endif

    expand({KEY1, 128'h0}, 4);
    run_op("backpressure", CT1, 2'd0, 10, PT1, 5);

    data_in  = CT1;
    key_len  = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midop_rst_flags", {125'd0, out_valid, busy, in_ready}, 128'd0);
    chk("midop_rst_data", data_out, 128'd0);
    rst = 1'b0;
    #1;
    chk("midop_rst_ready", 128'(in_ready), 128'(1));
    run_op("after_rst", CT1, 2'd0, 10, PT1, 0);

    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      kl  = 2'($urandom_range(0, 3));
`ifdef AES_DEC_LONGKEY_EN
      nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
`else
      nk = 4;
`endif
      expand(key, nk);
      run_op($sformatf("rand%0d", n), ct, kl, nk + 6, ref_dec(ct, nk + 6),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
